// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with a 1-tick producer pipeline.
// Define PIXEL_DIV2_EN to advance the raster only on every second CLK (half-rate pixel tick).
module vga_timing_gen #(
  parameter int H_CNT_WID = 10,
  parameter int V_CNT_WID = 10,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic [H_CNT_WID-1:0] H_CNT,
  output logic [V_CNT_WID-1:0] next_V_CNT,
  output logic                 H_BLANKING,
  output logic                 NEXT_FRAME,
  input  logic [3:0]           r,
  input  logic [3:0]           g,
  input  logic [3:0]           b,
  output logic [3:0]           VGA_R,
  output logic [3:0]           VGA_G,
  output logic [3:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS
);

  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_VIS_U    = H_VISIBLE;
  localparam int unsigned V_VIS_U    = V_VISIBLE;
  localparam int unsigned H_LAST_U   = H_TOTAL - 1;
  localparam int unsigned V_LAST_U   = V_TOTAL - 1;
  localparam int unsigned V_FRAME_U  = V_VISIBLE - 1;
  localparam int unsigned HS_START   = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END     = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned VS_START   = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END     = V_VISIBLE + V_FRONT + V_SYNC;
  localparam logic [V_CNT_WID-1:0] V_LAST = V_CNT_WID'(V_TOTAL - 1);

  // Refuse geometries whose counters cannot hold every position of the raster.
  if (H_CNT_WID < 32 && H_TOTAL > (32'd1 << H_CNT_WID)) begin : g_h_range
    $error("vga_timing_gen: H_TOTAL does not fit in H_CNT_WID bits");
  end
  if (V_CNT_WID < 32 && V_TOTAL > (32'd1 << V_CNT_WID)) begin : g_v_range
    $error("vga_timing_gen: V_TOTAL does not fit in V_CNT_WID bits");
  end

  logic                 tick;
  logic [H_CNT_WID-1:0] h_cnt;
  logic [V_CNT_WID-1:0] v_cnt;
  logic [V_CNT_WID-1:0] next_v;
  logic [31:0]          h_ext;
  logic [31:0]          v_ext;
  logic                 h_last;
  logic                 v_last;
  logic                 visible;
  logic                 hs_raw;
  logic                 vs_raw;
  logic                 vis_q;
  logic                 hs_d1;
  logic                 vs_d1;

`ifdef PIXEL_DIV2_EN
  logic tick_en;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tick_en <= 1'b0;
    else        tick_en <= ~tick_en;
  end

  assign tick = tick_en;
`else
  assign tick = 1'b1;
`endif

  assign h_ext   = 32'(h_cnt);
  assign v_ext   = 32'(v_cnt);
  assign h_last  = (h_ext == H_LAST_U);
  assign v_last  = (v_ext == V_LAST_U);
  assign visible = (h_ext < H_VIS_U) && (v_ext < V_VIS_U);
  assign hs_raw  = !((h_ext >= HS_START) && (h_ext < HS_END));
  assign vs_raw  = !((v_ext >= VS_START) && (v_ext < VS_END));

  assign H_CNT      = h_cnt;
  assign next_V_CNT = next_v;
  assign H_BLANKING = (h_ext >= H_VIS_U);
  assign NEXT_FRAME = tick && h_last && (v_ext == V_FRAME_U);

  // next_v tracks v_cnt one line ahead so the producer sees a registered value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      next_v <= V_CNT_WID'(1);
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) v_cnt <= '0;
        else        v_cnt <= v_cnt + 1'b1;
        if (next_v == V_LAST) next_v <= '0;
        else                  next_v <= next_v + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Visible flag and syncs are delayed so they line up with the producer's 1-tick latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vis_q  <= 1'b0;
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (tick) begin
      vis_q  <= visible;
      hs_d1  <= hs_raw;
      vs_d1  <= vs_raw;
      VGA_R  <= vis_q ? r : 4'd0;
      VGA_G  <= vis_q ? g : 4'd0;
      VGA_B  <= vis_q ? b : 4'd0;
      VGA_HS <= hs_d1;
      VGA_VS <= vs_d1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster.
module tb_vga_timing_gen;

  localparam int HV = 16;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 6;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VV + VF + VS + VB;
  localparam int HW = 5;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] next_v;
  logic          h_blank;
  logic          next_frame;
  logic [3:0]    r = '0;
  logic [3:0]    g = '0;
  logic [3:0]    b = '0;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;
  logic          vga_hs;
  logic          vga_vs;

  typedef struct {
    int tag;
    int h;
    int nv;
    bit hb;
    bit nf;
    int cr;
    int cg;
    int cb;
    bit hs;
    bit vs;
  } exp_t;

  typedef struct {
    bit vis;
    bit hs;
    bit vs;
    int r;
    int g;
    int b;
  } pix_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_bad;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   nf_exp = 0;
  int   nf_seen = 0;
  int   k = 0;
  bit   pd1_ok = 1'b0;
  bit   pd2_ok = 1'b0;
  pix_t pd1;
  pix_t pd2;

  vga_timing_gen #(
    .H_CNT_WID(HW), .V_CNT_WID(VW),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .H_CNT(h_cnt), .next_V_CNT(next_v),
    .H_BLANKING(h_blank), .NEXT_FRAME(next_frame),
    .r(r), .g(g), .b(b),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs)
  );

  always #5 clk = ~clk;

  // One tick of stimulus: drive reset/colour just after the edge and queue what the raster must show.
  task automatic step(input bit rst_val);
    exp_t e;
    pix_t cur;
    int   h;
    int   v;
    @(posedge clk);
    #1;
    rst_n = rst_val;
    e.tag = -1; e.h = 0; e.nv = 1; e.hb = 1'b0; e.nf = 1'b0;
    e.cr = 0; e.cg = 0; e.cb = 0; e.hs = 1'b1; e.vs = 1'b1;
    r = 4'($urandom_range(0, 15));
    g = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    if (!rst_val) begin
      k = 0;
      pd1_ok = 1'b0;
      pd2_ok = 1'b0;
    end else begin
      h = k % HT;
      v = (k / HT) % VT;
      cur.vis = (h < HV) && (v < VV);
      cur.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
      cur.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
      cur.r   = h % 16;
      cur.g   = $urandom_range(0, 15);
      cur.b   = $urandom_range(0, 15);
      if (pd1_ok) begin
        r = 4'(pd1.r);
        g = 4'(pd1.g);
        b = 4'(pd1.b);
      end
      e.tag = k;
      e.h   = h;
      e.nv  = (v + 1) % VT;
      e.hb  = (h >= HV);
      e.nf  = (h == HT - 1) && (v == VV - 1);
      if (pd2_ok) begin
        e.cr = pd2.vis ? pd2.r : 0;
        e.cg = pd2.vis ? pd2.g : 0;
        e.cb = pd2.vis ? pd2.b : 0;
        e.hs = pd2.hs;
        e.vs = pd2.vs;
      end
      if (e.nf) nf_exp++;
      pd2    = pd1;
      pd2_ok = pd1_ok;
      pd1    = cur;
      pd1_ok = 1'b1;
      k++;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests_run++;
      if (next_frame) nf_seen++;
      mon_bad = (int'(h_cnt) != mon_e.h) || (int'(next_v) != mon_e.nv) ||
                (h_blank != mon_e.hb) || (next_frame != mon_e.nf) ||
                (int'(vga_r) != mon_e.cr) || (int'(vga_g) != mon_e.cg) ||
                (int'(vga_b) != mon_e.cb) || (vga_hs != mon_e.hs) || (vga_vs != mon_e.vs);
      if (mon_bad) begin
        tests_failed++;
        $display("FAIL tick %0d: got h=%0d nv=%0d hb=%0b nf=%0b rgb=%0d/%0d/%0d hs=%0b vs=%0b, want h=%0d nv=%0d hb=%0b nf=%0b rgb=%0d/%0d/%0d hs=%0b vs=%0b",
                 mon_e.tag, h_cnt, next_v, h_blank, next_frame, vga_r, vga_g, vga_b, vga_hs, vga_vs,
                 mon_e.h, mon_e.nv, mon_e.hb, mon_e.nf, mon_e.cr, mon_e.cg, mon_e.cb, mon_e.hs, mon_e.vs);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (4) step(1'b0);
    repeat (2 * HT * VT + 40) step(1'b1);
    for (int rep = 0; rep < 4; rep++) begin
      n = $urandom_range(HT * VV - 40, 2 * HT * VT);
      repeat (n) step(1'b1);
      repeat (3) step(1'b0);
    end
    repeat (HT * VT + 10) step(1'b1);
    @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    tests_run++;
    if (nf_seen != nf_exp) begin
      tests_failed++;
      $display("FAIL next_frame_count: got %0d pulses, want %0d", nf_seen, nf_exp);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_CNT_WID, 10, width of H_CNT.
REQ-002 Parameter V_CNT_WID, 10, width of next_V_CNT.
REQ-003 Parameters H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixels; H_TOTAL = sum (800).
REQ-004 Parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines; V_TOTAL = sum (525).
REQ-005 CLK  in  1  single clock; pixel clock unless PIXEL_DIV2_EN is defined.
REQ-006 RST_N  in  1  asynchronous reset, active-low.
REQ-007 H_CNT  out  H_CNT_WID  current horizontal pixel counter, to producer.
REQ-008 next_V_CNT  out  V_CNT_WID  line index following the current line, to producer.
REQ-009 H_BLANKING  out  1  high while H_CNT >= H_VISIBLE.
REQ-010 NEXT_FRAME  out  1  one-cycle frame-update pulse, to producer.
REQ-011 r, g, b  in  4 each  pixel colour from producer.
REQ-012 VGA_R, VGA_G, VGA_B  out  4 each  registered colour to DAC.
REQ-013 VGA_HS, VGA_VS  out  1 each  sync outputs, active-low.

Function
REQ-014 h_cnt counts 0..H_TOTAL-1 once per pixel tick, wraps to 0; v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, wraps to 0.
REQ-015 H_CNT = h_cnt; next_V_CNT = (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1, both driven from registers.
REQ-016 NEXT_FRAME high for exactly one pixel tick when h_cnt == H_TOTAL-1 and v_cnt == V_VISIBLE-1 (end of last visible line); never otherwise.
REQ-017 Producer latency fixed at 1 tick: r/g/b sampled at tick t+1 belong to H_CNT presented at tick t.
REQ-018 Visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE), evaluated at tick t, pipelined 1 tick to align with r/g/b.
REQ-019 VGA_R/G/B registered at tick t+1 (appear at t+2) = aligned visible ? r/g/b : 0.
REQ-020 VGA_HS low when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC; VGA_VS low when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC; both delayed 2 ticks to align with VGA_R/G/B.
REQ-021 Counter comparisons use full-width unsigned arithmetic; parameters with H_TOTAL > 2^H_CNT_WID or V_TOTAL > 2^V_CNT_WID are illegal (elaboration error).
REQ-022 Simultaneous h and v wrap (h_cnt == H_TOTAL-1, v_cnt == V_TOTAL-1) yields (0,0) next tick, next_V_CNT = 1.

Reset
REQ-023 RST_N low asynchronously forces h_cnt = 0, v_cnt = 0, pipeline cleared.
REQ-024 During reset: H_CNT = 0, next_V_CNT = 1, H_BLANKING = 0, NEXT_FRAME = 0, VGA_R/G/B = 0, VGA_HS = VGA_VS = 1.
REQ-025 Reset asserted mid-frame abandons the frame; after release counting restarts at (0,0) on the first CLK rising edge, NEXT_FRAME not emitted for the abandoned frame.

Configuration
REQ-026 Macro PIXEL_DIV2_EN defined: internal tick enable toggles every CLK (low out of reset); counters, pipeline and output registers advance only on enabled cycles; NEXT_FRAME asserted for exactly one CLK cycle, on the enabled cycle; producer latency measured in ticks, not CLKs.
REQ-027 PIXEL_DIV2_EN undefined: every CLK cycle is a tick; no enable logic present.

Verification
REQ-028 Release reset, run 800*525 ticks -> exactly one NEXT_FRAME pulse at tick 800*480-1 from release; h_cnt/v_cnt back at (0,0) at tick 420000.
REQ-029 Count VGA_HS low per line -> 96 ticks, falling edge 656+2 ticks after line start; VGA_VS low for 2 lines starting line 490 (+2 tick offset).
REQ-030 Producer drives r = H_CNT[3:0] registered 1 tick -> VGA_R equals (h mod 16) for h < 640 on visible lines, 0 for h >= 640 and on lines 480..524.
REQ-031 Observe next_V_CNT on line 524 -> 0; on line 0 -> 1; H_BLANKING rises at H_CNT = 640, falls at H_CNT = 0.
REQ-032 Assert RST_N low at (h=300, v=200) for 3 cycles -> outputs at reset values immediately (asynchronous); after release H_CNT = 0, 1, 2...; no NEXT_FRAME until tick 383999.
REQ-033 With PIXEL_DIV2_EN: H_CNT holds each value 2 CLK cycles, frame = 840000 CLKs, NEXT_FRAME width = 1 CLK.
